// File: rtl/mult_seq.sv
// mult_seq: sequential 32x32 -> 64-bit multiplier, one step per clock.
// Signed operation uses radix-2 Booth recoding over a 33-bit accumulator.
// The optional unsigned (multu) add-shift datapath and the mult_unsigned port
// exist only when the MULT_UNSIGNED_EN macro is defined.
// Every operation takes exactly 32 RUN cycles. hi/lo change only on completion.

module mult_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_control,
  input  logic [31:0] A,
  input  logic [31:0] B,
`ifdef MULT_UNSIGNED_EN
  input  logic        mult_unsigned,
`endif
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        mult_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] mcand_r;     // latched multiplicand
  logic [32:0] acc_r;       // accumulator; the extra bit keeps -2^31 in range
  logic [31:0] q_r;         // multiplier, shifted out as product bits shift in
  logic        qm1_r;       // Booth q_-1 bit
  logic [4:0]  count_r;     // completed RUN steps
`ifdef MULT_UNSIGNED_EN
  logic        unsigned_r;  // operation mode latched at start
`endif

  logic [32:0] msext_s;
  logic [32:0] bsum_s;
  logic [32:0] booth_acc_s;
  logic [31:0] booth_q_s;
  logic        booth_qm1_s;
  logic [32:0] acc_next_s;
  logic [31:0] q_next_s;
  logic        qm1_next_s;
`ifdef MULT_UNSIGNED_EN
  logic [32:0] usum_s;
`endif

  // One Booth step: add/subtract the multiplicand per {q0,q_-1}, then arithmetic shift right.
  always_comb begin
    msext_s = {mcand_r[31], mcand_r};
    case ({q_r[0], qm1_r})
      2'b10:   bsum_s = acc_r - msext_s;
      2'b01:   bsum_s = acc_r + msext_s;
      default: bsum_s = acc_r;
    endcase
    booth_acc_s = {bsum_s[32], bsum_s[32:1]};
    booth_q_s   = {bsum_s[0], q_r[31:1]};
    booth_qm1_s = q_r[0];
  end

  // Choose the step applied this cycle; the unsigned add-shift path exists only with the option.
  always_comb begin
    acc_next_s = booth_acc_s;
    q_next_s   = booth_q_s;
    qm1_next_s = booth_qm1_s;
`ifdef MULT_UNSIGNED_EN
    if (q_r[0]) begin
      usum_s = {1'b0, acc_r[31:0]} + {1'b0, mcand_r};
    end else begin
      usum_s = {1'b0, acc_r[31:0]};
    end
    if (unsigned_r) begin
      // Carry becomes the new top product bit; logical shift of {carry, acc, q}.
      acc_next_s = {1'b0, usum_s[32:1]};
      q_next_s   = {usum_s[0], q_r[31:1]};
      qm1_next_s = q_r[0];
    end else begin
      acc_next_s = booth_acc_s;
      q_next_s   = booth_q_s;
      qm1_next_s = booth_qm1_s;
    end
`endif
  end

  // Control FSM and datapath registers; results are published only on the final step.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      mcand_r    <= 32'd0;
      acc_r      <= 33'd0;
      q_r        <= 32'd0;
      qm1_r      <= 1'b0;
      count_r    <= 5'd0;
`ifdef MULT_UNSIGNED_EN
      unsigned_r <= 1'b0;
`endif
      hi         <= 32'd0;
      lo         <= 32'd0;
      busy       <= 1'b0;
      mult_done  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          mult_done <= 1'b0;
          if (mult_control) begin
            mcand_r    <= A;
            q_r        <= B;
            acc_r      <= 33'd0;
            qm1_r      <= 1'b0;
            count_r    <= 5'd0;
`ifdef MULT_UNSIGNED_EN
            unsigned_r <= mult_unsigned;
`endif
            busy       <= 1'b1;
            state_r    <= RUN;
          end
        end
        RUN: begin
          acc_r   <= acc_next_s;
          q_r     <= q_next_s;
          qm1_r   <= qm1_next_s;
          count_r <= count_r + 5'd1;
          if (count_r == 5'd31) begin
            hi        <= acc_next_s[31:0];
            lo        <= q_next_s;
            mult_done <= 1'b1;
            busy      <= 1'b0;
            state_r   <= DONE;
          end
        end
        DONE: begin
          mult_done <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          mult_done <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: a transaction-level model (plain 64-bit
// multiplication plus a cycle count since start) is compared against the DUT
// on every cycle, with literal expectations for the known corner cases.

module tb_mult_seq;

  logic        clk;
  logic        reset;
  logic        mult_control;
  logic [31:0] A;
  logic [31:0] B;
  logic        mult_unsigned;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        mult_done;

  int pass_cnt;
  int total_cnt;

  mult_seq dut (
    .clk          (clk),
    .reset        (reset),
    .mult_control (mult_control),
    .A            (A),
    .B            (B),
`ifdef MULT_UNSIGNED_EN
    .mult_unsigned(mult_unsigned),
`endif
    .hi           (hi),
    .lo           (lo),
    .busy         (busy),
    .mult_done    (mult_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // phase: 0 = idle, 1..32 = cycles since the accepted start, 33 = result cycle
  int          phase;
  logic [63:0] pend_prod;
  logic [31:0] exp_hi, exp_lo;
  logic        exp_busy, exp_done;
  logic        chk_en;

  initial begin
    phase = 0; chk_en = 1'b0;
    exp_hi = 32'd0; exp_lo = 32'd0; exp_busy = 1'b0; exp_done = 1'b0;
    pend_prod = 64'd0;
  end

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic u);
    longint pa, pb;
    if (u) begin
      pa = longint'({32'd0, a});
      pb = longint'({32'd0, b});
    end else begin
      pa = longint'($signed(a));
      pb = longint'($signed(b));
    end
    return 64'(pa * pb);
  endfunction

  always @(posedge clk) begin
    logic u;
`ifdef MULT_UNSIGNED_EN
    u = mult_unsigned;
`else
    u = 1'b0;
`endif
    if (reset) begin
      phase = 0; exp_hi = 32'd0; exp_lo = 32'd0; chk_en = 1'b1;
    end else if (phase == 0) begin
      if (mult_control) begin
        pend_prod = ref_prod(A, B, u);
        phase = 1;
      end
    end else if (phase < 32) begin
      phase = phase + 1;
    end else if (phase == 32) begin
      exp_hi = pend_prod[63:32];
      exp_lo = pend_prod[31:0];
      phase = 33;
    end else begin
      phase = 0;
    end
    exp_busy = (phase >= 1 && phase <= 32);
    exp_done = (phase == 33);
  end

  // Per-cycle compare, just after each active edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("busy", {63'd0, busy}, {63'd0, exp_busy});
      chk("mult_done", {63'd0, mult_done}, {63'd0, exp_done});
      chk("hi", {32'd0, hi}, {32'd0, exp_hi});
      chk("lo", {32'd0, lo}, {32'd0, exp_lo});
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(input bit noise);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (mult_done) begin
        found = 1'b1;
        mult_control = 1'b0;
      end else if (noise) begin
        mult_control = ($urandom_range(0, 3) == 0);
        A = $urandom(); B = $urandom();
      end
    end
    if (!found) begin
      total_cnt++;
      $display("FAIL wait_done: mult_done not seen within 40 cycles");
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic u);
    @(negedge clk);
    A = a; B = b; mult_unsigned = u; mult_control = 1'b1;
    @(negedge clk);
    mult_control = 1'b0;
    A = $urandom(); B = $urandom(); mult_unsigned = ~u;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic u);
    start_op(a, b, u);
    wait_done(1'b0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    pass_cnt = 0; total_cnt = 0;
    reset = 1'b1; mult_control = 1'b0; A = 32'd0; B = 32'd0; mult_unsigned = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, mult_done}, 64'd0);
    reset = 1'b0;

    // 7 * -3
    run_op(32'd7, 32'hFFFF_FFFD, 1'b0);
    chk("r028_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    chk("r028_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFEB);
    @(negedge clk);
    chk("r028_pulse_width", {63'd0, mult_done}, 64'd0);

    // most-negative squared, and -1 squared
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0);
    chk("r029a_hi", {32'd0, hi}, 64'h0000_0000_4000_0000);
    chk("r029a_lo", {32'd0, lo}, 64'd0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    chk("r029b_hi", {32'd0, hi}, 64'd0);
    chk("r029b_lo", {32'd0, lo}, 64'd1);

`ifdef MULT_UNSIGNED_EN
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    chk("r030_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
    chk("r030_lo", {32'd0, lo}, 64'd1);
`endif

    // start ignored while running
    @(negedge clk);
    A = 32'd5; B = 32'd6; mult_unsigned = 1'b0; mult_control = 1'b1;
    @(negedge clk);
    mult_control = 1'b0;
    repeat (9) @(negedge clk);
    A = 32'd9; B = 32'd9; mult_control = 1'b1;
    @(negedge clk);
    mult_control = 1'b0;
    wait_done(1'b0);
    chk("r031_hi", {32'd0, hi}, 64'd0);
    chk("r031_lo", {32'd0, lo}, 64'd30);
    repeat (3) @(negedge clk);
    chk("r031_no_restart", {63'd0, busy}, 64'd0);

    // reset aborts an operation in flight
    start_op(32'h0001_0003, 32'h0002_0005, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("r032_hi", {32'd0, hi}, 64'd0);
    chk("r032_lo", {32'd0, lo}, 64'd0);
    chk("r032_busy", {63'd0, busy}, 64'd0);
    repeat (35) @(negedge clk);
    run_op(32'h1234_5678, 32'd0, 1'b0);
    chk("r032_zero_hi", {32'd0, hi}, 64'd0);
    chk("r032_zero_lo", {32'd0, lo}, 64'd0);

    // randomized traffic with start noise, back-to-back starts and aborts
    for (int n = 0; n < 40; n++) begin
      logic u;
`ifdef MULT_UNSIGNED_EN
      u = $urandom_range(0, 1);
`else
      u = 1'b0;
`endif
      start_op(pick_operand(), pick_operand(), u);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 30)) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else begin
        wait_done(1'b1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 mult_control  input  1  start request; sampled only while IDLE.
REQ-004 A  input  32  multiplicand, signed two's complement unless unsigned mode is selected.
REQ-005 B  input  32  multiplier, same encoding as A.
REQ-006 mult_unsigned  input  1  present only when MULT_UNSIGNED_EN is defined; 1 = unsigned (multu) operation.
REQ-007 hi  output  32  upper 32 bits of the 64-bit product (registered).
REQ-008 lo  output  32  lower 32 bits of the 64-bit product (registered).
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 mult_done  output  1  single-cycle pulse marking a valid hi/lo update.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE, mult_control=1 at an edge SHALL latch A, B and (if present) mult_unsigned, clear the accumulator and the step counter, and move to RUN.
REQ-013 RUN SHALL execute one step per clock for exactly 32 edges.
REQ-014 In signed mode each step SHALL be radix-2 Booth: inspect {q0, q_-1}; 10 subtracts the multiplicand, 01 adds it, 00/11 do nothing; then arithmetic shift right of {acc, q, q_-1} by 1.
REQ-015 The accumulator SHALL be 33 bits wide so that A = 0x80000000 never overflows.
REQ-016 In unsigned mode each step SHALL be add-shift: if q0=1, add the zero-extended multiplicand; then logical shift right of {carry, acc, q} by 1.
REQ-017 On the 32nd RUN edge the FSM SHALL go to DONE, load hi = acc[31:0] and lo = q, and assert mult_done for the following cycle.
REQ-018 Latency: for a start accepted at edge k, hi/lo SHALL update at edge k+32, mult_done SHALL be high between edges k+32 and k+33, and the FSM SHALL return to IDLE at k+33.
REQ-019 busy SHALL be high from edge k through edge k+32 and low in DONE and IDLE.
REQ-020 mult_control SHALL be ignored while in RUN or DONE; operand changes after the start SHALL have no effect.
REQ-021 hi/lo SHALL hold their last completed result until the next completion or reset; partial products SHALL never be visible on hi/lo.
REQ-022 A zero operand SHALL still take the full 32 cycles, with no early termination.
REQ-023 Back-to-back operation: a start is accepted at the IDLE edge immediately after DONE, giving a minimum start-to-start spacing of 34 cycles.

Reset
REQ-024 reset=1 SHALL force the state to IDLE and clear the following to zero: hi, lo, busy, mult_done, accumulator, counter and latched operands.
REQ-025 reset SHALL take priority over mult_control and over any in-flight operation; an aborted operation SHALL produce no mult_done and no hi/lo update.

Configuration
REQ-026 With MULT_UNSIGNED_EN defined, the mult_unsigned port SHALL exist and select between REQ-014 and REQ-016 per operation.
REQ-027 Without MULT_UNSIGNED_EN, the port SHALL be absent, the operation SHALL always be signed Booth, and the unsigned datapath SHALL not be built.

Verification
REQ-028 A=7, B=0xFFFFFFFD, start at edge k -> hi=0xFFFFFFFF, lo=0xFFFFFFEB at edge k+32, mult_done pulse for exactly 1 cycle.
REQ-029 A=B=0x80000000 signed -> hi=0x40000000, lo=0x00000000; A=B=0xFFFFFFFF signed -> hi=0, lo=1.
REQ-030 MULT_UNSIGNED_EN, mult_unsigned=1, A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 Start A=5, B=6, then pulse mult_control with A=9, B=9 at edge k+10 -> result hi=0, lo=30, and no second operation starts.
REQ-032 Start, then assert reset at edge k+10 -> from the next cycle hi=lo=0, busy=0, no mult_done; a fresh start with A=0x12345678, B=0 -> hi=lo=0 after 32 cycles.
